// File: rtl/reg_dump_ctrl.sv
//------------------------------------------------------------------------------
// reg_dump_ctrl
//
// Purpose:
//   Walks the CPU register file one register at a time by forcing an
//   "addi $0,$k,0" instruction into the CPU. That instruction reads $k onto
//   register-read bus A and writes only $0, so the architectural state is not
//   disturbed. Each forced instruction is held for SETTLE_CYCLES cycles so the
//   pipeline can settle. busA is then captured into a 32x32 dump buffer and
//   also streamed out as a dump_valid pulse. After $31 the block pulses done
//   for one cycle and releases the instruction override.
//
// Parameters:
//   SETTLE_CYCLES  cycles each forced instruction is held before busA is
//                  sampled (legal range 1..15)
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high reset
//   start          one-cycle request to begin a full 32-register dump
//   abort          terminates a dump in progress
//   busA_probe     CPU register-read bus A
//   override_inst  1 = force_inst feeds the CPU instead of normal fetch
//   force_inst     instruction injected into the CPU
//   busy           dump in progress (ISSUE or CAPTURE)
//   done           one-cycle pulse when a dump completes normally
//   dump_valid     one-cycle pulse per captured register
//   dump_idx       register index of the current capture
//   dump_data      value captured for dump_idx
//   rd_addr        dump buffer read address
//   rd_data        dump buffer contents at rd_addr (combinational)
//------------------------------------------------------------------------------
module reg_dump_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] busA_probe,
    output logic        override_inst,
    output logic [31:0] force_inst,
    output logic        busy,
    output logic        done,
    output logic        dump_valid,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    // Counter reload value. The counter counts down to zero, so a hold of
    // SETTLE_CYCLES cycles in ISSUE needs a reload of SETTLE_CYCLES-1.
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    // Opcode of addi; rt is left at $0 so the forced instruction never writes
    // anything the program can observe.
    localparam logic [5:0] AddiOpcode = 6'b001000;

    localparam logic [4:0] LastIdx = 5'd31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  dump_idx_q;
    logic [31:0] dump_data_q;
    logic [31:0] buf_q [32];
    logic        capture;
    logic        forcing;

    // Next-state logic. abort always wins over the normal progression, which
    // also suppresses the capture on the final ISSUE edge. Because idx only
    // advances from CAPTURE when it is below 31, it can never wrap back to 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    idx_d   = 5'd0;
                    cnt_d   = SettleLoad;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != LastIdx) begin
                    idx_d   = idx_q + 5'd1;
                    cnt_d   = SettleLoad;
                    state_d = ISSUE;
                end else begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Streamed capture registers. These update on the same edge as the buffer
    // write, so they are valid throughout the CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dump_idx_q  <= 5'd0;
            dump_data_q <= 32'd0;
        end else if (capture) begin
            dump_idx_q  <= idx_q;
            dump_data_q <= busA_probe;
        end
    end

    // Dump buffer. Only the capture path writes it. Entries captured before an
    // abort are therefore kept until the next dump overwrites them or reset
    // clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else if (capture) begin
            buf_q[idx_q] <= busA_probe;
        end
    end

    // The read port is asynchronous. A read of the address being captured
    // returns the old contents until the capture edge has passed.
    assign rd_data = buf_q[rd_addr];

    // Moore outputs. The forced instruction stays on the CPU through CAPTURE,
    // so the value sampled on the capture edge is not disturbed by a change of
    // instruction in the same cycle.
    assign forcing       = (state_q == ISSUE) || (state_q == CAPTURE);
    assign override_inst = forcing;
    assign force_inst    = forcing ? {AddiOpcode, idx_q, 5'b00000, 16'h0000} : 32'h0;
    assign busy          = forcing;
    assign done          = (state_q == FINISH);
    assign dump_valid    = (state_q == CAPTURE);
    assign dump_idx      = dump_idx_q;
    assign dump_data     = dump_data_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
//------------------------------------------------------------------------------
// tb_reg_dump_ctrl
//
// Purpose:
//   Self-checking bench for reg_dump_ctrl. It has two instances:
//     dut    : SETTLE_CYCLES=2, which covers the main scenarios
//     dutOne : SETTLE_CYCLES=1, which covers the shorter dump length
//   A small CPU model returns $k = k*0x11111111 on bus A. It does so only while
//   a well-formed "addi $0,$k,0" is being forced, and returns a junk value
//   otherwise. Expected captures are queued when a dump is started and are
//   popped as dump_valid pulses arrive.
//------------------------------------------------------------------------------
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] busAProbe;
    logic        overrideInst;
    logic [31:0] forceInst;
    logic        busy;
    logic        done;
    logic        dumpValid;
    logic [4:0]  dumpIdx;
    logic [31:0] dumpData;
    logic [4:0]  rdAddr = 5'd0;
    logic [31:0] rdData;

    logic        startOne = 1'b0;
    logic        abortOne = 1'b0;
    logic [31:0] busAOne;
    logic        overrideOne;
    logic [31:0] forceOne;
    logic        busyOne;
    logic        doneOne;
    logic        validOne;
    logic [4:0]  dumpIdxOne;
    logic [31:0] dumpDataOne;
    logic [4:0]  rdAddrOne = 5'd0;
    logic [31:0] rdDataOne;

    int passCount = 0;
    int checkCount = 0;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } entry_t;

    entry_t sbQueue[$];

    reg_dump_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busA_probe(busAProbe), .override_inst(overrideInst), .force_inst(forceInst),
        .busy(busy), .done(done), .dump_valid(dumpValid), .dump_idx(dumpIdx),
        .dump_data(dumpData), .rd_addr(rdAddr), .rd_data(rdData)
    );

    reg_dump_ctrl #(.SETTLE_CYCLES(1)) dutOne (
        .clk(clk), .reset(reset), .start(startOne), .abort(abortOne),
        .busA_probe(busAOne), .override_inst(overrideOne), .force_inst(forceOne),
        .busy(busyOne), .done(doneOne), .dump_valid(validOne), .dump_idx(dumpIdxOne),
        .dump_data(dumpDataOne), .rd_addr(rdAddrOne), .rd_data(rdDataOne)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] regVal(input logic [4:0] k);
        return 32'(k) * 32'h1111_1111;
    endfunction

    // CPU model: bus A reflects the register named by a correctly formed
    // forced addi, and returns junk otherwise.
    always_comb begin
        busAProbe = 32'hDEAD_BEEF;
        if (overrideInst && forceInst[31:26] == 6'b001000 && forceInst[20:0] == 21'd0)
            busAProbe = regVal(forceInst[25:21]);
    end

    always_comb begin
        busAOne = 32'hDEAD_BEEF;
        if (overrideOne && forceOne[31:26] == 6'b001000 && forceOne[20:0] == 21'd0)
            busAOne = regVal(forceOne[25:21]);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutputsZero(input string tag);
        checkCount++;
        if ({busy, done, dumpValid, overrideInst} !== 4'b0000)
            $display("[TB] FAIL %s_flags: got busy/done/valid/ovr=%b want 0000", tag,
                     {busy, done, dumpValid, overrideInst});
        else passCount++;
        checkCount++;
        if (forceInst !== 32'h0 || dumpIdx !== 5'd0 || dumpData !== 32'h0)
            $display("[TB] FAIL %s_data: got force=%h idx=%0d data=%h want 0/0/0", tag,
                     forceInst, dumpIdx, dumpData);
        else passCount++;
        for (int i = 0; i < 32; i++) begin
            rdAddr = 5'(i);
            #1;
            checkCount++;
            if (rdData !== 32'h0)
                $display("[TB] FAIL %s_buf%0d: got %h want 00000000", tag, i, rdData);
            else passCount++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutputsZero("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Runs one full dump on dut and checks it. When repulseStart is set, start
    // is re-pulsed during the capture of idx 4 and again in the done cycle.
    task automatic runFullDump(input string tag, input bit repulseStart);
        int edges;
        int validSeen;
        int doneSeen;
        int doneAt;
        entry_t e;
        for (int k = 0; k < 32; k++) sbQueue.push_back({5'(k), regVal(5'(k))});
        start = 1'b1;
        @(negedge clk);
        edges = 0; validSeen = 0; doneSeen = 0; doneAt = -1;
        while (edges < 150) begin
            start = 1'b0;
            if (repulseStart && doneSeen == 1 && edges == doneAt + 1) begin
                checkCount++;
                if (busy !== 1'b0)
                    $display("[TB] FAIL %s_start_in_finish: got busy=%b want 0", tag, busy);
                else passCount++;
            end
            if (dumpValid) begin
                if (sbQueue.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL %s_extra_valid: got idx=%0d want no capture", tag, dumpIdx);
                end else begin
                    e = sbQueue.pop_front();
                    checkCount++;
                    if (dumpIdx !== e.idx || dumpData !== e.data)
                        $display("[TB] FAIL %s_capture: got idx=%0d data=%h want idx=%0d data=%h",
                                 tag, dumpIdx, dumpData, e.idx, e.data);
                    else passCount++;
                    checkCount++;
                    if (edges !== 2 + 3 * validSeen)
                        $display("[TB] FAIL %s_spacing: got cycle %0d want %0d for idx %0d",
                                 tag, edges, 2 + 3 * validSeen, e.idx);
                    else passCount++;
                    if (e.idx == 5'd5) begin
                        checkCount++;
                        if (forceInst !== 32'h20A0_0000 || overrideInst !== 1'b1)
                            $display("[TB] FAIL %s_force5: got force=%h ovr=%b want 20a00000/1",
                                     tag, forceInst, overrideInst);
                        else passCount++;
                    end
                    if (repulseStart && e.idx == 5'd4) start = 1'b1;
                end
                validSeen++;
            end
            if (done) begin
                doneSeen++;
                if (doneAt < 0) doneAt = edges;
                if (repulseStart) start = 1'b1;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        checkCount++;
        if (doneSeen !== 1)
            $display("[TB] FAIL %s_done_count: got %0d want 1", tag, doneSeen);
        else passCount++;
        checkCount++;
        if (doneAt + 1 !== 97)
            $display("[TB] FAIL %s_done_time: got %0d cycles want 97", tag, doneAt + 1);
        else passCount++;
        checkCount++;
        if (validSeen !== 32 || sbQueue.size() !== 0)
            $display("[TB] FAIL %s_valid_count: got %0d left=%0d want 32 left=0",
                     tag, validSeen, sbQueue.size());
        else passCount++;
        sbQueue.delete();
        checkCount++;
        if (overrideInst !== 1'b0 || forceInst !== 32'h0 || busy !== 1'b0)
            $display("[TB] FAIL %s_after_done: got ovr=%b force=%h busy=%b want 0/0/0",
                     tag, overrideInst, forceInst, busy);
        else passCount++;
        for (int i = 0; i < 32; i++) begin
            rdAddr = 5'(i);
            #1;
            checkCount++;
            if (rdData !== regVal(5'(i)))
                $display("[TB] FAIL %s_buf%0d: got %h want %h", tag, i, rdData, regVal(5'(i)));
            else passCount++;
        end
    endtask

    task automatic test_full_dump();
        runFullDump("full", 1'b0);
    endtask

    task automatic test_start_ignored();
        runFullDump("restart", 1'b1);
    endtask

    task automatic test_idle_controls();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || overrideInst !== 1'b0)
            $display("[TB] FAIL idle_abort: got busy=%b ovr=%b want 0/0", busy, overrideInst);
        else passCount++;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || overrideInst !== 1'b0 || forceInst !== 32'h0)
            $display("[TB] FAIL start_abort_idle: got busy=%b ovr=%b force=%h want 0/0/0",
                     busy, overrideInst, forceInst);
        else passCount++;
        repeat (3) @(negedge clk);
        checkCount++;
        if (busy !== 1'b0)
            $display("[TB] FAIL idle_stays: got busy=%b want 0", busy);
        else passCount++;
    endtask

    task automatic test_abort();
        int cyc;
        int stray;
        entry_t e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) sbQueue.push_back({5'(k), regVal(5'(k))});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(dumpValid && dumpIdx == 5'd9)) begin
            if (dumpValid && sbQueue.size() != 0) begin
                e = sbQueue.pop_front();
                checkCount++;
                if (dumpIdx !== e.idx || dumpData !== e.data)
                    $display("[TB] FAIL abort_capture: got idx=%0d data=%h want idx=%0d data=%h",
                             dumpIdx, dumpData, e.idx, e.data);
                else passCount++;
            end
            @(negedge clk);
            cyc++;
        end
        checkCount++;
        if (cyc >= 200)
            $display("[TB] FAIL abort_reach9: got timeout want capture of idx 9");
        else passCount++;
        if (sbQueue.size() != 0) begin
            e = sbQueue.pop_front();
            checkCount++;
            if (dumpIdx !== e.idx || dumpData !== e.data)
                $display("[TB] FAIL abort_capture9: got idx=%0d data=%h want idx=%0d data=%h",
                         dumpIdx, dumpData, e.idx, e.data);
            else passCount++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || dumpValid !== 1'b0 || overrideInst !== 1'b0)
            $display("[TB] FAIL abort_busy: got busy=%b valid=%b ovr=%b want 0/0/0",
                     busy, dumpValid, overrideInst);
        else passCount++;
        stray = 0;
        repeat (40) begin
            if (done || dumpValid || busy) stray++;
            @(negedge clk);
        end
        checkCount++;
        if (stray !== 0)
            $display("[TB] FAIL abort_quiet: got %0d active cycles want 0", stray);
        else passCount++;
        checkCount++;
        if (sbQueue.size() !== 0)
            $display("[TB] FAIL abort_queue: got %0d pending want 0", sbQueue.size());
        else passCount++;
        sbQueue.delete();
        for (int i = 0; i < 32; i++) begin
            rdAddr = 5'(i);
            #1;
            checkCount++;
            if (rdData !== (i <= 9 ? regVal(5'(i)) : 32'h0))
                $display("[TB] FAIL abort_buf%0d: got %h want %h", i, rdData,
                         (i <= 9 ? regVal(5'(i)) : 32'h0));
            else passCount++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(dumpValid && dumpIdx == 5'd20)) begin
            @(negedge clk);
            cyc++;
        end
        checkCount++;
        if (cyc >= 200)
            $display("[TB] FAIL reset_mid_reach20: got timeout want capture of idx 20");
        else passCount++;
        reset = 1'b1;
        @(negedge clk);
        checkOutputsZero("reset_mid");
        reset = 1'b0;
        @(negedge clk);
        runFullDump("post_reset", 1'b0);
    endtask

    task automatic test_settle_one();
        int edges;
        int doneAt;
        int validSeen;
        entry_t e;
        for (int k = 0; k < 32; k++) sbQueue.push_back({5'(k), regVal(5'(k))});
        startOne = 1'b1;
        @(negedge clk);
        startOne = 1'b0;
        edges = 0; doneAt = -1; validSeen = 0;
        while (edges < 120) begin
            if (validOne && sbQueue.size() != 0) begin
                e = sbQueue.pop_front();
                checkCount++;
                if (dumpIdxOne !== e.idx || dumpDataOne !== e.data || edges !== 1 + 2 * validSeen)
                    $display("[TB] FAIL settle1_capture: got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                             dumpIdxOne, dumpDataOne, edges, e.idx, e.data, 1 + 2 * validSeen);
                else passCount++;
            end
            if (validOne) validSeen++;
            if (doneOne && doneAt < 0) doneAt = edges;
            @(negedge clk);
            edges++;
        end
        checkCount++;
        if (doneAt + 1 !== 65)
            $display("[TB] FAIL settle1_done_time: got %0d cycles want 65", doneAt + 1);
        else passCount++;
        checkCount++;
        if (validSeen !== 32 || sbQueue.size() !== 0)
            $display("[TB] FAIL settle1_count: got %0d left=%0d want 32 left=0",
                     validSeen, sbQueue.size());
        else passCount++;
        sbQueue.delete();
        rdAddrOne = 5'd31;
        #1;
        checkCount++;
        if (rdDataOne !== 32'h1111_110F)
            $display("[TB] FAIL settle1_buf31: got %h want 1111110f", rdDataOne);
        else passCount++;
    endtask

    initial begin
        $display("[TB] starting reg_dump_ctrl bench");
        test_reset();
        test_full_dump();
        test_idle_controls();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_settle_one();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
